// File: rtl/si4463_spi_responder.sv
// si4463_spi_responder: SPI-slave stand-in for the Si4463 radio command interface.
// Decodes the opcode, answers READ_CMD_BUFF with CTS, and holds the radio TX/RX FIFOs.
// Build option SI4463_LOOPBACK_EN: the TX FIFO drains straight into the RX FIFO and
// the model-side TX/RX ports are ignored.
//
// state  | meaning
// IDLE   | deselected, waiting for ss_n fall
// OPCODE | shifting in the command byte
// WR_TX  | payload bytes are pushed into the TX FIFO
// RD_RX  | RX FIFO bytes are shifted out on miso
// RD_CMD | READ_CMD_BUFF, first reply byte carries CTS
// ARGS   | generic command, argument bytes discarded
module si4463_spi_responder #(
    parameter int FIFO_DEPTH = 64,
    parameter int CTS_DELAY  = 16,
    parameter int RX_THRESH  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       ss_n,
    output logic       irq_n,
    input  logic       tx_rd,
    output logic [7:0] tx_data,
    output logic       tx_empty,
    input  logic       rx_wr,
    input  logic [7:0] rx_data,
    output logic       rx_full,
    output logic       cmd_strobe,
    output logic [7:0] cmd_opcode
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CTS_DELAY + 1);
    localparam logic [7:0] OP_WRITE_TX  = 8'h66;
    localparam logic [7:0] OP_READ_RX   = 8'h77;
    localparam logic [7:0] OP_READ_CMD  = 8'h44;
    localparam logic [7:0] OP_FIFO_INFO = 8'h15;

    typedef enum logic [2:0] {IDLE, OPCODE, WR_TX, RD_RX, RD_CMD, ARGS} state_t;
    state_t state_q, state_d, nxt_state;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [7:0] in_byte;

    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    in_sr_q, in_sr_d;
    logic [7:0]    out_sr_q, out_sr_d, opcode_q, opcode_d, cmd_opcode_q, cmd_opcode_d;
    logic          cmd_strobe_q, cmd_strobe_d, irq_n_q, irq_n_d;
    logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, rx_valid_q, rx_valid_d;
    logic          cts_snap_q, cts_snap_d, cts;
    logic [CW-1:0] cts_cnt_q, cts_cnt_d;

    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW:0] rx_count;
    logic        tx_empty_i, tx_full_i, rx_empty_i, rx_full_i;
    logic        spi_tx_push, spi_rx_pop, tx_pop, rx_push;
    logic [7:0]  tx_head, rx_head, rx_next, rx_wdata;

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign ss_rise   = ss_sync_q & ~ss_prev_q;
    assign ss_fall   = ~ss_sync_q & ss_prev_q;
    assign in_byte   = {in_sr_q, mosi_sync_q};
    assign cts       = (cts_cnt_q == '0);

    assign tx_empty_i = (tx_wp_q == tx_rp_q);
    assign tx_full_i  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty_i = (rx_wp_q == rx_rp_q);
    assign rx_full_i  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_count   = rx_wp_q - rx_rp_q;
    assign tx_head    = tx_mem_q[tx_rp_q[AW-1:0]];
    assign rx_head    = rx_mem_q[rx_rp_q[AW-1:0]];
    assign rx_next    = rx_mem_q[rx_rp_q[AW-1:0] + AW'(1)];

`ifdef SI4463_LOOPBACK_EN
    logic lb_move;
    assign lb_move  = !tx_empty_i && !rx_full_i;
    assign tx_pop   = lb_move;
    assign rx_push  = lb_move;
    assign rx_wdata = tx_head;
    assign tx_empty = 1'b1;
    assign tx_data  = 8'h00;
`else
    assign tx_pop   = tx_rd;
    assign rx_push  = rx_wr;
    assign rx_wdata = rx_data;
    assign tx_empty = tx_empty_i;
    assign tx_data  = tx_head;
`endif

    assign miso       = out_sr_q[7];
    assign irq_n      = irq_n_q;
    assign rx_full    = rx_full_i;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_opcode = cmd_opcode_q;

    // Command FSM, byte assembly, reply shifting and CTS timer
    always_comb begin
        state_d      = state_q;
        nxt_state    = state_q;
        bit_cnt_d    = bit_cnt_q;
        in_sr_d      = in_sr_q;
        out_sr_d     = out_sr_q;
        opcode_d     = opcode_q;
        cmd_opcode_d = cmd_opcode_q;
        cmd_strobe_d = 1'b0;
        tx_ovf_d     = tx_ovf_q;
        rx_unf_d     = rx_unf_q;
        rx_valid_d   = rx_valid_q;
        cts_snap_d   = cts_snap_q;
        cts_cnt_d    = cts ? cts_cnt_q : cts_cnt_q - 1'b1;
        spi_tx_push  = 1'b0;
        spi_rx_pop   = 1'b0;
        irq_n_d      = !((rx_count >= (AW+1)'(RX_THRESH)) || tx_ovf_q || rx_unf_q);
        if (ss_rise) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            out_sr_d   = 8'h00;
            rx_valid_d = 1'b0;
            if (state_q == ARGS) begin
                cmd_opcode_d = opcode_q;
                cmd_strobe_d = 1'b1;
                cts_cnt_d    = CW'(CTS_DELAY);
                if (opcode_q == OP_FIFO_INFO) begin
                    tx_ovf_d = 1'b0;
                    rx_unf_d = 1'b0;
                end
            end
        end else if (state_q == IDLE) begin
            if (ss_fall) begin
                state_d    = OPCODE;
                bit_cnt_d  = 3'd0;
                out_sr_d   = 8'h00;
                // CTS is captured at select so a READ_CMD_BUFF right behind a command sees busy
                cts_snap_d = cts;
            end
        end else begin
            // the falling edge right after a byte boundary presents the freshly loaded MSB
            if (sclk_fall && bit_cnt_q != 3'd0) out_sr_d = {out_sr_q[6:0], 1'b0};
            if (sclk_rise) begin
                in_sr_d   = in_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (sclk_rise && bit_cnt_q == 3'd7) begin
                if (state_q == OPCODE) begin
                    opcode_d = in_byte;
                    case (in_byte)
                        OP_WRITE_TX: nxt_state = WR_TX;
                        OP_READ_RX:  nxt_state = RD_RX;
                        OP_READ_CMD: nxt_state = RD_CMD;
                        default:     nxt_state = ARGS;
                    endcase
                end
                if (state_q == WR_TX) begin
                    if (tx_full_i) tx_ovf_d = 1'b1;
                    else           spi_tx_push = 1'b1;
                end
                if (state_q == RD_RX) begin
                    if (rx_valid_q) spi_rx_pop = 1'b1;
                    else            rx_unf_d = 1'b1;
                end
                state_d    = nxt_state;
                out_sr_d   = 8'h00;
                rx_valid_d = 1'b0;
                if (nxt_state == RD_RX) begin
                    if (spi_rx_pop) begin
                        if (rx_count > (AW+1)'(1)) begin
                            out_sr_d   = rx_next;
                            rx_valid_d = 1'b1;
                        end
                    end else if (!rx_empty_i) begin
                        out_sr_d   = rx_head;
                        rx_valid_d = 1'b1;
                    end
                end else if (nxt_state == RD_CMD && state_q == OPCODE) begin
                    out_sr_d = cts_snap_q ? 8'hFF : 8'h00;
                end
            end
        end
    end

    // FIFO pointer advance; push on full and pop on empty are dropped
    always_comb begin
        tx_wp_d = tx_wp_q;
        tx_rp_d = tx_rp_q;
        rx_wp_d = rx_wp_q;
        rx_rp_d = rx_rp_q;
        if (spi_tx_push && !tx_full_i) tx_wp_d = tx_wp_q + 1'b1;
        if (tx_pop && !tx_empty_i)     tx_rp_d = tx_rp_q + 1'b1;
        if (rx_push && !rx_full_i)     rx_wp_d = rx_wp_q + 1'b1;
        if (spi_rx_pop && !rx_empty_i) rx_rp_d = rx_rp_q + 1'b1;
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (spi_tx_push && !tx_full_i) tx_mem_q[tx_wp_q[AW-1:0]] <= in_byte;
        if (rx_push && !rx_full_i)     rx_mem_q[rx_wp_q[AW-1:0]] <= rx_wdata;
    end

    // State registers; ss_n synchroniser resets low so a select held across reset is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_meta_q  <= 1'b0;
            sclk_sync_q  <= 1'b0;
            sclk_prev_q  <= 1'b0;
            mosi_meta_q  <= 1'b0;
            mosi_sync_q  <= 1'b0;
            ss_meta_q    <= 1'b0;
            ss_sync_q    <= 1'b0;
            ss_prev_q    <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            in_sr_q      <= 7'h00;
            out_sr_q     <= 8'h00;
            opcode_q     <= 8'h00;
            cmd_opcode_q <= 8'h00;
            cmd_strobe_q <= 1'b0;
            irq_n_q      <= 1'b1;
            tx_ovf_q     <= 1'b0;
            rx_unf_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            cts_snap_q   <= 1'b1;
            cts_cnt_q    <= '0;
            tx_wp_q      <= '0;
            tx_rp_q      <= '0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
        end else begin
            sclk_meta_q  <= sclk;
            sclk_sync_q  <= sclk_meta_q;
            sclk_prev_q  <= sclk_sync_q;
            mosi_meta_q  <= mosi;
            mosi_sync_q  <= mosi_meta_q;
            ss_meta_q    <= ss_n;
            ss_sync_q    <= ss_meta_q;
            ss_prev_q    <= ss_sync_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            in_sr_q      <= in_sr_d;
            out_sr_q     <= out_sr_d;
            opcode_q     <= opcode_d;
            cmd_opcode_q <= cmd_opcode_d;
            cmd_strobe_q <= cmd_strobe_d;
            irq_n_q      <= irq_n_d;
            tx_ovf_q     <= tx_ovf_d;
            rx_unf_q     <= rx_unf_d;
            rx_valid_q   <= rx_valid_d;
            cts_snap_q   <= cts_snap_d;
            cts_cnt_q    <= cts_cnt_d;
            tx_wp_q      <= tx_wp_d;
            tx_rp_q      <= tx_rp_d;
            rx_wp_q      <= rx_wp_d;
            rx_rp_q      <= rx_rp_d;
        end
    end
endmodule

// File: tb/tb_si4463_spi_responder.sv
// Bench for si4463_spi_responder: SPI master plus radio-model ports, scoreboard queues
// hold expected miso bytes, expected TX FIFO output and the RX FIFO contents.
module tb_si4463_spi_responder;
    logic       clk = 1'b0, reset = 1'b1, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic       tx_rd = 1'b0, rx_wr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       miso, irq_n, tx_empty, rx_full, cmd_strobe;
    logic [7:0] tx_data, cmd_opcode;

    int vectors = 0, miscompares = 0, strobe_cnt = 0;
    logic [7:0] mo_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_model_q[$];

    si4463_spi_responder dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n),
        .irq_n(irq_n), .tx_rd(tx_rd), .tx_data(tx_data), .tx_empty(tx_empty),
        .rx_wr(rx_wr), .rx_data(rx_data), .rx_full(rx_full),
        .cmd_strobe(cmd_strobe), .cmd_opcode(cmd_opcode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_strobe) strobe_cnt++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: mosi set while sclk low, miso sampled just before the rising edge
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #50 r[i] = miso;
            sclk = 1'b1;
            #50 sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic chk, input logic [7:0] e);
        mo_q.push_back(b);
        exp_q.push_back({chk, e});
    endtask

    task automatic xfer();
        logic [7:0] r;
        logic [8:0] e;
        @(negedge clk);
        ss_n = 1'b0;
        #60;
        while (mo_q.size() > 0) begin
            spi_bits(mo_q.pop_front(), 8, r);
            e = exp_q.pop_front();
            if (e[8]) check_val("miso_byte", r, e[7:0]);
        end
        #60 ss_n = 1'b1;
        #60;
    endtask

    task automatic rx_write(input logic [7:0] d);
        @(negedge clk);
        rx_data = d;
        rx_wr   = 1'b1;
        @(negedge clk);
        rx_wr   = 1'b0;
    endtask

    task automatic tx_read();
        @(negedge clk);
        check_val("tx_data", tx_data, tx_exp_q.pop_front());
        tx_rd = 1'b1;
        @(negedge clk);
        tx_rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_miso"}, miso, 1'b0);
        check_val({pfx, "_irq_n"}, irq_n, 1'b1);
        check_val({pfx, "_tx_empty"}, tx_empty, 1'b1);
        check_val({pfx, "_rx_full"}, rx_full, 1'b0);
        check_val({pfx, "_cmd_strobe"}, cmd_strobe, 1'b0);
        check_val({pfx, "_cmd_opcode"}, cmd_opcode, 8'h00);
    endtask

    initial begin
        logic [7:0] r;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
`ifdef SI4463_LOOPBACK_EN
        send(8'h66, 1'b0, 8'h00); send(8'h3C, 1'b0, 8'h00); xfer();
        repeat (4) @(negedge clk);
        send(8'h77, 1'b0, 8'h00); send(8'h00, 1'b1, 8'h3C); xfer();
        check_val("lb_tx_empty", tx_empty, 1'b1);
        check_val("lb_tx_data", tx_data, 8'h00);
`else
        // READ_CMD_BUFF with CTS idle
        send(8'h44, 1'b0, 8'h00); send(8'h00, 1'b1, 8'hFF); xfer();
        check_val("irq_idle", irq_n, 1'b1);

        // generic command, then READ_CMD_BUFF while busy, then after the delay
        send(8'h11, 1'b0, 8'h00); send(8'h01, 1'b0, 8'h00); send(8'h02, 1'b0, 8'h00); xfer();
        check_val("strobe_once", strobe_cnt, 1);
        check_val("cmd_opcode_11", cmd_opcode, 8'h11);
        send(8'h44, 1'b0, 8'h00); send(8'h00, 1'b1, 8'h00); xfer();
        repeat (20) @(negedge clk);
        send(8'h44, 1'b0, 8'h00); send(8'h00, 1'b1, 8'hFF); xfer();
        check_val("no_strobe_on_read_cmd", strobe_cnt, 1);

        // TX write and model-side reads
        send(8'h66, 1'b0, 8'h00);
        send(8'hA5, 1'b0, 8'h00); tx_exp_q.push_back(8'hA5);
        send(8'h5A, 1'b0, 8'h00); tx_exp_q.push_back(8'h5A);
        xfer();
        check_val("tx_not_empty", tx_empty, 1'b0);
        tx_read();
        tx_read();
        @(negedge clk);
        check_val("tx_empty_after_reads", tx_empty, 1'b1);

        // RX threshold and SPI read-back
        for (int i = 0; i < 31; i++) begin
            rx_write(8'(i));
            rx_model_q.push_back(8'(i));
        end
        repeat (3) @(negedge clk);
        check_val("irq_below_thresh", irq_n, 1'b1);
        rx_write(8'd31);
        rx_model_q.push_back(8'd31);
        check_val("irq_latency", irq_n, 1'b1);
        @(negedge clk);
        check_val("irq_at_thresh", irq_n, 1'b0);
        send(8'h77, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) send(8'h00, 1'b1, rx_model_q.pop_front());
        xfer();
        repeat (3) @(negedge clk);
        check_val("irq_after_rx_read", irq_n, 1'b1);

        // TX overflow: 65th byte dropped
        send(8'h66, 1'b0, 8'h00);
        for (int i = 0; i < 65; i++) begin
            send(8'(i) ^ 8'h5C, 1'b0, 8'h00);
            if (i < 64) tx_exp_q.push_back(8'(i) ^ 8'h5C);
        end
        xfer();
        repeat (3) @(negedge clk);
        check_val("irq_tx_ovf", irq_n, 1'b0);
        for (int i = 0; i < 64; i++) tx_read();
        @(negedge clk);
        check_val("tx_65th_absent", tx_empty, 1'b1);
        send(8'h15, 1'b0, 8'h00); xfer();
        repeat (3) @(negedge clk);
        check_val("irq_ovf_cleared", irq_n, 1'b1);
        check_val("cmd_opcode_15", cmd_opcode, 8'h15);

        // RX underflow
        send(8'h77, 1'b0, 8'h00); send(8'h00, 1'b1, 8'h00); xfer();
        repeat (3) @(negedge clk);
        check_val("irq_rx_unf", irq_n, 1'b0);
        send(8'h15, 1'b0, 8'h00); xfer();
        repeat (3) @(negedge clk);
        check_val("irq_unf_cleared", irq_n, 1'b1);

        // RX full boundary
        for (int i = 0; i < 64; i++) rx_write(8'(i) + 8'h40);
        @(negedge clk);
        check_val("rx_full_at_depth", rx_full, 1'b1);

        // deselect after 4 payload bits: nothing pushed
        @(negedge clk);
        ss_n = 1'b0;
        #60;
        spi_bits(8'h66, 8, r);
        spi_bits(8'hC3, 4, r);
        #60 ss_n = 1'b1;
        #100;
        check_val("partial_byte_dropped", tx_empty, 1'b1);

        // reset in the middle of a byte, select held low across it
        @(negedge clk);
        ss_n = 1'b0;
        #60;
        spi_bits(8'h66, 8, r);
        spi_bits(8'hC3, 4, r);
        reset = 1'b1;
        #20;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        spi_bits(8'h3C, 4, r);
        #60 ss_n = 1'b1;
        #100;
        check_reset_outputs("post_rst");
        send(8'h77, 1'b0, 8'h00); send(8'h00, 1'b1, 8'h00); xfer();
        send(8'h44, 1'b0, 8'h00); send(8'h00, 1'b1, 8'hFF); xfer();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/si4463_spi_responder.md
Name: si4463_spi_responder

Overview:
- SPI-slave emulation of the Si4463 command interface. It is the responder on the other end of the link the radio SPI master drives.
- Used in loopback builds and on the verification bench in place of the physical radio.
- Decodes the opcode, runs the CTS handshake via READ_CMD_BUFF, and holds the radio's 64-byte TX and RX FIFOs.
- External FIFO ports let a radio/channel model consume transmitted bytes and inject received ones.

Parameters:
FIFO_DEPTH, 64, entries per FIFO (power of 2)
CTS_DELAY, 16, clk cycles CTS stays low after a generic command ends
RX_THRESH, 32, RX FIFO count at or above which irq_n asserts

Ports:
clk  in  1  system clock, at least 8x sclk
reset  in  1  asynchronous, active-high
sclk  in  1  SPI clock from master, mode 0
mosi  in  1  SPI data in, MSB first
miso  out  1  SPI data out
ss_n  in  1  SPI select, active-low
irq_n  out  1  radio interrupt, active-low
tx_rd  in  1  pop one TX FIFO byte (model side)
tx_data  out  8  TX FIFO head byte
tx_empty  out  1  TX FIFO empty
rx_wr  in  1  push rx_data into RX FIFO (model side)
rx_data  in  8  byte to push
rx_full  out  1  RX FIFO full
cmd_strobe  out  1  1-cycle pulse when a generic command completes
cmd_opcode  out  8  opcode of the last generic command; held until the next one

Behaviour:
- Reset values:
  - miso=0, irq_n=1, tx_empty=1, rx_full=0, cmd_strobe=0, cmd_opcode=0x00.
  - cts=1, FIFOs empty, sticky flags clear, FSM in IDLE.
- Synchronisation:
  - sclk, mosi and ss_n pass through 2-flop synchronisers; edges are detected on the synchronised sclk.
  - mosi is sampled on the rising edge; miso updates on the falling edge.
  - The first reply bit is valid within 3 clk of a byte boundary.
- Byte assembly:
  - 8 rising edges make one byte, with a bit counter of 0..7.
  - ss_n rising mid-byte discards the partial byte.
- FSM states: IDLE, OPCODE, WR_TX, RD_RX, RD_CMD, ARGS.
  - IDLE -> OPCODE on ss_n fall.
  - The first byte of OPCODE selects the next state:
    - 0x66 -> WR_TX
    - 0x77 -> RD_RX
    - 0x44 -> RD_CMD
    - anything else -> ARGS
  - Any state -> IDLE on ss_n rise.
- WR_TX: each complete byte is pushed to the TX FIFO. If the FIFO is full, the byte is dropped and sticky tx_ovf is set.
- RD_RX: the RX FIFO head is loaded into the shift register at each byte boundary and popped at the byte's 8th rising edge. If the FIFO is empty, 0x00 is shifted out and sticky rx_unf is set.
- RD_CMD: the first reply byte is 0xFF if cts=1, else 0x00; all further reply bytes are 0x00.
- ARGS:
  - Argument bytes are discarded.
  - On ss_n rise: cmd_opcode <= opcode, cmd_strobe pulses, cts <= 0, and a down-counter loads CTS_DELAY.
  - cts returns to 1 when the counter reaches 0.
  - A new generic command while cts=0 restarts the counter.
- Opcode 0x15 (FIFO_INFO): as ARGS, and additionally clears tx_ovf and rx_unf on ss_n rise.
- FIFOs:
  - Circular buffers with log2(FIFO_DEPTH)+1-bit pointers; full/empty come from the MSB-difference compare.
  - A simultaneous push and pop on the same FIFO in the same cycle both take effect, and the count is unchanged.
  - A push on a full FIFO or a pop on an empty FIFO is ignored.
  - tx_rd while tx_empty=1 and rx_wr while rx_full=1 are ignored.
- irq_n = 0 when RX count >= RX_THRESH, or tx_ovf, or rx_unf; otherwise 1. irq_n is registered, giving 1 cycle of latency.
- Reset mid-transaction:
  - All state is cleared immediately.
  - The byte in flight is lost.
  - After reset is released, the responder waits for the next ss_n fall; an ongoing low ss_n is ignored until it rises.

Optional Feature:
Macro SI4463_LOOPBACK_EN.
- Defined:
  - The TX FIFO head moves to the RX FIFO, one byte per clk, whenever TX is not empty and RX is not full.
  - tx_rd and rx_wr are ignored; tx_empty is held 1; tx_data is held 0x00.
- Undefined: the FIFOs are independent and serviced only through the external ports.

Test Plan:
- Reset, then READ_CMD_BUFF (0x44 + 1 dummy byte) -> reply byte 1 = 0xFF; irq_n = 1.
- Generic command 0x11 0x01 0x02, then immediate 0x44 -> reply 0x00; cmd_strobe pulses once with cmd_opcode = 0x11. After CTS_DELAY=16 clk, 0x44 -> 0xFF.
- 0x66 followed by 0xA5, 0x5A -> tx_empty falls; tx_rd x2 yields 0xA5 then 0x5A; tx_empty = 1.
- rx_wr 32 bytes 0x00..0x1F -> irq_n = 0 one cycle after the 32nd write. 0x77 read of 32 bytes -> MISO returns 0x00..0x1F in order, then irq_n = 1.
- Overflow/underflow:
  - 65 bytes via 0x66 -> tx_ovf set, irq_n = 0, 65th byte absent.
  - 0x77 on an empty RX FIFO -> 0x00 and rx_unf set.
  - 0x15 clears both flags -> irq_n = 1.
- ss_n rise after 4 bits of a 0x66 payload, then a separate reset asserted mid-byte -> no FIFO push; all outputs at reset values.
- SI4463_LOOPBACK_EN: 0x66 0x3C, then 0x77 -> MISO returns 0x3C.
